// File: rtl/tone_gen_pkg.sv
// Shared widths, default amplitude and phase encoding for the tone generator.
package tone_gen_pkg;
  localparam int unsigned DIV_W       = 22;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned FRAME_CNT_W = 10;
  localparam int unsigned FRAME_W     = 2 * SAMPLE_W;

  localparam logic [SAMPLE_W-1:0] DEFAULT_AMP = 16'h2000;

  typedef enum logic {
    PHASE_LOW  = 1'b0,
    PHASE_HIGH = 1'b1
  } phase_t;

  // Volume 0 mutes the channel instead of giving AMP >> 7.
  function automatic logic [SAMPLE_W-1:0] scale_amp(input logic [SAMPLE_W-1:0] amp,
                                                    input logic [2:0]          volume);
    if (volume == '0) return '0;
    return amp >> (3'd7 - volume);
  endfunction
endpackage

// File: rtl/tone_osc.sv
// One square-wave channel: half-period counter, phase bit and signed sample.
module tone_osc
  import tone_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIV_W-1:0]    div,
  input  logic [SAMPLE_W-1:0] amp,
  output logic                phase,
  output logic [SAMPLE_W-1:0] sample
);

  logic [DIV_W-1:0] count;
  phase_t           state;

  // A div change never restarts the count; a smaller div simply trips the >= test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      state <= PHASE_LOW;
    end else if (div == '0) begin
      count <= '0;
      state <= PHASE_LOW;
    end else if (count >= div) begin
      count <= '0;
      state <= (state == PHASE_HIGH) ? PHASE_LOW : PHASE_HIGH;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

  always_comb begin
    phase = (state == PHASE_HIGH);
    if (div == '0) begin
      sample = '0;
    end else if (phase) begin
      sample = amp;
    end else begin
      sample = '0 - amp;
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Two-channel square-wave tone generator with a left-justified serial DAC link.
// Optional TONE_GEN_VOLUME_EN adds a 3-bit volume input scaling the amplitude.
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] AMP = DEFAULT_AMP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] left_note_div,
  input  logic [DIV_W-1:0] right_note_div,
`ifdef TONE_GEN_VOLUME_EN
  input  logic [2:0]       volume,
`endif
  output logic             audio_mclk,
  output logic             audio_lrck,
  output logic             audio_sck,
  output logic             audio_sdin
);

  logic [SAMPLE_W-1:0]    amp_eff;
  logic [SAMPLE_W-1:0]    left_sample;
  logic [SAMPLE_W-1:0]    right_sample;
  logic                   left_phase;
  logic                   right_phase;
  logic [FRAME_CNT_W-1:0] fc;
  logic [FRAME_W-1:0]     frame;
  logic [FRAME_W-1:0]     frame_next;
  logic                   sdin_q;

`ifdef TONE_GEN_VOLUME_EN
  assign amp_eff = scale_amp(AMP, volume);
`else
  assign amp_eff = AMP;
`endif

  tone_osc u_left (
    .clk    (clk),
    .rst_n  (rst_n),
    .div    (left_note_div),
    .amp    (amp_eff),
    .phase  (left_phase),
    .sample (left_sample)
  );

  tone_osc u_right (
    .clk    (clk),
    .rst_n  (rst_n),
    .div    (right_note_div),
    .amp    (amp_eff),
    .phase  (right_phase),
    .sample (right_sample)
  );

  // Both samples are captured in the same edge so a frame never mixes old and new.
  always_comb begin
    frame_next = frame;
    if (fc == '0) frame_next = {left_sample, right_sample};
  end

  // Slot bits come from frame_next so the very first bit of a fresh frame is
  // already the new MSB; 31 - slot is the bitwise inverse of the 5-bit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc     <= '0;
      frame  <= '0;
      sdin_q <= 1'b0;
    end else begin
      fc    <= fc + FRAME_CNT_W'(1);
      frame <= frame_next;
      if (fc[4:0] == '0) sdin_q <= frame_next[~fc[FRAME_CNT_W-1 -: 5]];
    end
  end

  assign audio_mclk = fc[1];
  assign audio_sck  = fc[4];
  assign audio_lrck = fc[FRAME_CNT_W-1];
  assign audio_sdin = sdin_q;

  logic unused_phase;
  assign unused_phase = left_phase ^ right_phase;

endmodule
